// File: rtl/interp_mac_sequencer.sv
// interp_mac_sequencer: zero-stuffing interpolator running one TAPS-cycle shared-multiplier MAC per modulator tick.
// Define INTERP_SATURATE_EN to clamp the output to 2^N-1 instead of wrapping.
module interp_mac_sequencer #(
  parameter int N = 8,
  parameter int TAPS = 4,
  parameter int L = 4,
  parameter int SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mod_req,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [N-1:0]            coef_data,
  output logic [N-1:0]            out_data,
  output logic                    out_valid,
  output logic                    busy,
  output logic [2:0]              status
);
  localparam int CW = $clog2(TAPS);
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int AW = 2 * N + CW;
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MAC = 2'd2, S_DONE = 2'd3;
  logic [1:0]    r_state;
  logic [PW-1:0] r_phase;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_hist [TAPS];
  logic [N-1:0]  r_coef [TAPS];
  logic [AW-1:0] r_acc;
  logic [N-1:0]  r_out;
  logic          r_out_valid;
  logic [2:0]    r_status;
  logic          w_idle, w_slot, w_take;
  logic [N-1:0]  w_new, w_out;
  logic [2*N-1:0] w_prod;
  logic [AW-1:0] w_sh;
  assign w_idle = r_state == S_IDLE;
  assign w_slot = r_state == S_SHIFT && r_phase == '0;
  assign w_take = w_slot && in_valid;
  assign w_new  = w_take ? in_data : '0;
  assign w_prod = {{N{1'b0}}, r_hist[r_cnt]} * {{N{1'b0}}, r_coef[r_cnt]};
  assign w_sh   = r_acc >> SHIFT;
`ifdef INTERP_SATURATE_EN
  assign w_out  = (|w_sh[AW-1:N]) ? '1 : w_sh[N-1:0];
`else
  assign w_out  = w_sh[N-1:0];
`endif
  assign in_ready  = w_take;
  assign busy      = !w_idle;
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign status    = r_status;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_status    <= '0;
      for (int k = 0; k < TAPS; k++) begin
        r_hist[k] <= '0;
        r_coef[k] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      // a write coinciding with mod_req lands before the MAC reads it
      if (coef_we && w_idle) r_coef[coef_addr] <= coef_data;
      r_status <= r_status | {coef_we && !w_idle, mod_req && !w_idle, w_slot && !in_valid};
      case (r_state)
        S_IDLE: if (mod_req) r_state <= S_SHIFT;
        S_SHIFT: begin
          for (int k = TAPS - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
          r_hist[0] <= w_new;
          r_phase   <= (r_phase == PW'(L - 1)) ? '0 : r_phase + 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_state   <= S_MAC;
        end
        S_MAC: begin
          r_acc <= r_acc + AW'(w_prod);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(TAPS - 1)) r_state <= S_DONE;
        end
        default: begin
          r_out       <= w_out;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_interp_mac_sequencer.sv
// tb_interp_mac_sequencer: table-driven and hand-sequenced checks of the interpolating MAC sequencer with a result scoreboard.
module tb_interp_mac_sequencer;
  localparam int TAPS = 4;
  typedef struct { logic [7:0] d; logic v; logic [7:0] exp; logic rdy; } vec_t;
  typedef struct { logic [7:0] d; int cyc; } exp_t;
  logic       clk = 0, reset = 1;
  logic [7:0] in_data = 0, coef_data = 0;
  logic       in_valid = 0, mod_req = 0, mod_req1 = 0, coef_we = 0;
  logic [1:0] coef_addr = 0;
  logic [7:0] out_data, out_data1;
  logic       out_valid, out_valid1, busy, busy1, in_ready, in_ready1;
  logic [2:0] status, status1;
  int         cyc = 0, n_chk = 0, n_fail = 0, n_ov = 0, ov0;
  exp_t       sb[$];
  vec_t       tbl[8];
  logic       seen;

  interp_mac_sequencer #(.N(8), .TAPS(TAPS), .L(4), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mod_req(mod_req), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .status(status));

  interp_mac_sequencer #(.N(8), .TAPS(TAPS), .L(1), .SHIFT(0)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .mod_req(mod_req1), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(out_data1), .out_valid(out_valid1), .busy(busy1), .status(status1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (out_valid) begin
    exp_t e;
    n_ov++;
    if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
    else begin
      e = sb.pop_front();
      chk("out_data", out_data, e.d);
      chk("latency", cyc, e.cyc);
    end
  end

  task automatic wcoef(input logic [7:0] c0, c1, c2, c3);
    logic [7:0] c[4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      coef_we = 1; coef_addr = 2'(i); coef_data = c[i];
      @(posedge clk); #1;
    end
    coef_we = 0;
  endtask

  task automatic start(input logic [7:0] d, input logic v, input logic we, input logic [1:0] a,
                       input logic [7:0] cd, input logic [7:0] exp, input logic rdy);
    in_data = d; in_valid = v; coef_we = we; coef_addr = a; coef_data = cd; mod_req = 1;
    sb.push_back('{exp, cyc + 1 + TAPS + 2});
    @(posedge clk); #1;
    mod_req = 0; coef_we = 0;
    chk("in_ready", in_ready, rdy);
    repeat (TAPS + 3) @(posedge clk);
    #1;
    chk("out_hold", out_data, exp);
  endtask

  initial begin
    tbl[0] = '{8'd10, 1'b1, 8'd10, 1'b1};
    tbl[1] = '{8'd10, 1'b1, 8'd30, 1'b0};
    tbl[2] = '{8'd10, 1'b1, 8'd30, 1'b0};
    tbl[3] = '{8'd10, 1'b1, 8'd10, 1'b0};
    tbl[4] = '{8'd20, 1'b1, 8'd20, 1'b1};
    tbl[5] = '{8'd20, 1'b1, 8'd60, 1'b0};
    tbl[6] = '{8'd20, 1'b1, 8'd60, 1'b0};
    tbl[7] = '{8'd20, 1'b1, 8'd20, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_status", status, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 0;
    @(posedge clk); #1;
    wcoef(1, 3, 3, 1);
    for (int i = 0; i < 8; i++) start(tbl[i].d, tbl[i].v, 0, 0, 0, tbl[i].exp, tbl[i].rdy);
    chk("status_clean", status, 3'b000);
    // phase 0 with no sample: zero shifted in, underrun flagged
    start(8'd99, 0, 0, 0, 0, 8'd0, 0);
    chk("underrun", status, 3'b001);
    // second mod_req lands in MAC and must be dropped
    ov0 = n_ov;
    mod_req = 1; sb.push_back('{8'd0, cyc + 1 + TAPS + 2});
    @(posedge clk); #1;
    mod_req = 0;
    @(posedge clk); #1;
    mod_req = 1;
    @(posedge clk); #1;
    mod_req = 0;
    repeat (TAPS + 4) @(posedge clk);
    #1;
    chk("overrun", status, 3'b011);
    chk("single_out_valid", n_ov - ov0, 1);
    // coefficient write during MAC is dropped
    mod_req = 1; sb.push_back('{8'd0, cyc + 1 + TAPS + 2});
    @(posedge clk); #1;
    mod_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_mac", busy, 1);
    coef_we = 1; coef_addr = 1; coef_data = 7;
    @(posedge clk); #1;
    coef_we = 0;
    repeat (TAPS + 2) @(posedge clk);
    #1;
    chk("cfg_err", status, 3'b111);
    start(8'd0, 1, 0, 0, 0, 8'd0, 0);
    start(8'd5, 1, 1, 2'd0, 8'd9, 8'd45, 1);
    start(8'd0, 0, 0, 0, 0, 8'd15, 0);
    // reset in the middle of MAC aborts the computation
    mod_req = 1;
    @(posedge clk); #1;
    mod_req = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_status", status, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    repeat (8) @(posedge clk);
    #1;
    wcoef(1, 3, 3, 1);
    start(8'd7, 1, 0, 0, 0, 8'd7, 1);
    // wrap/saturate on the L=1 instance with a full 255 history
    wcoef(255, 255, 255, 255);
    in_data = 255; in_valid = 1;
    for (int p = 0; p < 4; p++) begin
      mod_req1 = 1;
      @(posedge clk); #1;
      mod_req1 = 0;
      seen = 0;
      for (int t = 0; t < 12 && !seen; t++) begin
        @(posedge clk); #1;
        if (out_valid1) seen = 1;
      end
      chk("sat_out_valid_seen", seen, 1);
      @(posedge clk); #1;
    end
`ifdef INTERP_SATURATE_EN
    chk("sat_out_data", out_data1, 255);
`else
    chk("wrap_out_data", out_data1, 4);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
